// File: rtl/m2w_pkg.sv
// Shared codes, state encodings and width helpers for the mem_if-to-Wishbone pipelined bridge.
package m2w_pkg;

    localparam logic [2:0] REQ_READ   = 3'd0;
    localparam logic [2:0] REQ_WRITE  = 3'd1;

    localparam logic [2:0] RSP_RD_ACK = 3'd0;
    localparam logic [2:0] RSP_WR_ACK = 3'd1;
    localparam logic [2:0] RSP_ERR    = 3'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    // Data word returned when a Wishbone cycle is abandoned by the watchdog.
    localparam logic [31:0] TMO_DATA = 32'hDEAD_0000;

    function automatic int req_w(input int addr_w, input int data_w, input int tid_w);
        return 3 + tid_w + addr_w + data_w / 8 + data_w;
    endfunction

    function automatic int rsp_w(input int data_w, input int tid_w);
        return 3 + tid_w + data_w;
    endfunction

endpackage

// File: rtl/m2w_sync_fifo.sv
// Single-clock FIFO with combinational head read; pointers carry an extra wrap bit
// so full and empty are distinguishable.
module m2w_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/m2w_bridge_pipe.sv
// Queued mem_if-to-Wishbone classic bridge: request FIFO -> one-cycle-in-flight FSM -> response FIFO.
// Optional bus watchdog enabled by defining M2W_TIMEOUT_EN.
module m2w_bridge_pipe
    import m2w_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TID_W       = 16,
    parameter int REQ_DEPTH   = 4,
    parameter int RESP_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   mem_if_req_valid,
    output logic                                   mem_if_req_ready,
    input  logic [req_w(ADDR_W, DATA_W, TID_W)-1:0] mem_if_req,
    output logic                                   mem_if_resp_valid,
    input  logic                                   mem_if_resp_ready,
    output logic [rsp_w(DATA_W, TID_W)-1:0]        mem_if_resp,
    output logic                                   wb_cyc_o,
    output logic                                   wb_stb_o,
    output logic                                   wb_we_o,
    output logic [ADDR_W-1:0]                      wb_addr_o,
    output logic [DATA_W-1:0]                      wb_data_o,
    output logic [DATA_W/8-1:0]                    wb_sel_o,
    input  logic                                   wb_ack_i,
    input  logic                                   wb_err_i,
    input  logic [DATA_W-1:0]                      wb_data_i
);

    localparam int REQ_W = req_w(ADDR_W, DATA_W, TID_W);
    localparam int RSP_W = rsp_w(DATA_W, TID_W);
    localparam int SEL_W = DATA_W / 8;
    localparam int M_LSB = DATA_W;
    localparam int A_LSB = M_LSB + SEL_W;
    localparam int T_LSB = A_LSB + ADDR_W;

    state_t state_q, state_d;

    logic [REQ_W-1:0]              req_head;
    logic                          req_full, req_empty, req_pop, req_push;
    logic [$clog2(REQ_DEPTH):0]    req_count;
    logic [RSP_W-1:0]              rsp_din, rsp_head;
    logic                          rsp_full, rsp_empty, rsp_push;
    logic [$clog2(RESP_DEPTH):0]   rsp_count;

    logic [2:0]        head_type;
    logic [TID_W-1:0]  head_tid;
    logic              head_legal;
    logic              inflight, slot_free, tmo, bus_done, run;
    logic [2:0]        rsp_type;
    logic [DATA_W-1:0] rsp_data;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic [TID_W-1:0]  tid_q;

    logic unused_levels;
    assign unused_levels = ^{req_count, rsp_full};

    assign mem_if_req_ready = run && !req_full;
    assign req_push         = mem_if_req_valid && mem_if_req_ready;

    m2w_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .push  (req_push),
        .wdata (mem_if_req),
        .pop   (req_pop),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    m2w_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RESP_DEPTH)) u_rsp_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .push  (rsp_push),
        .wdata (rsp_din),
        .pop   (mem_if_resp_ready),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign mem_if_resp_valid = !rsp_empty;
    // Storage is not reset, so mask the head while empty to keep the port at 0.
    assign mem_if_resp       = rsp_empty ? '0 : rsp_head;

    assign head_type  = req_head[REQ_W-1 -: 3];
    assign head_tid   = req_head[T_LSB +: TID_W];
    assign head_legal = (head_type == REQ_READ) || (head_type == REQ_WRITE);

    // A slot is reserved for the cycle on the bus so its response can never be refused.
    assign inflight  = (state_q == ST_BUS);
    assign slot_free = (int'(rsp_count) + int'(inflight)) < RESP_DEPTH;
    assign bus_done  = (state_q == ST_BUS) && (wb_ack_i || wb_err_i || tmo);

`ifdef M2W_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                 tmo_cnt <= '0;
        else if (state_q == ST_IDLE) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo = (state_q == ST_BUS) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!req_empty && slot_free && head_legal) state_d = ST_BUS;
            ST_BUS:  if (wb_ack_i || wb_err_i || tmo)           state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_pop  = 1'b0;
        rsp_push = 1'b0;
        rsp_type = RSP_ERR;
        rsp_data = '0;
        case (state_q)
            ST_IDLE: begin
                // Illegal codes are answered straight from the queue head.
                req_pop  = !req_empty && slot_free;
                rsp_push = req_pop && !head_legal;
            end
            ST_BUS: begin
                rsp_push = bus_done;
                if (wb_err_i) begin
                    rsp_type = RSP_ERR;
                end else if (wb_ack_i) begin
                    rsp_type = we_q ? RSP_WR_ACK : RSP_RD_ACK;
                    rsp_data = we_q ? '0 : wb_data_i;
                end else begin
                    rsp_data = DATA_W'(TMO_DATA);
                end
            end
            default: ;
        endcase
    end

    assign rsp_din = {rsp_type, (state_q == ST_BUS) ? tid_q : head_tid, rsp_data};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= '0;
            tid_q  <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_BUS) begin
            we_q   <= (head_type == REQ_WRITE);
            addr_q <= req_head[A_LSB +: ADDR_W];
            data_q <= req_head[DATA_W-1:0];
            sel_q  <= req_head[M_LSB +: SEL_W];
            tid_q  <= head_tid;
        end else if (bus_done) begin
            we_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) run <= 1'b0;
        else         run <= 1'b1;
    end

    assign wb_cyc_o  = (state_q == ST_BUS);
    assign wb_stb_o  = (state_q == ST_BUS);
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;
    assign wb_sel_o  = sel_q;

endmodule

// File: tb/tb_m2w_bridge_pipe.sv
// Directed bench for m2w_bridge_pipe with a registered one-cycle-ack Wishbone slave model.
// Timeout scenario runs only when M2W_TIMEOUT_EN is defined.
module tb_m2w_bridge_pipe;

    localparam int ADDR_W = 32, DATA_W = 32, TID_W = 16;
    localparam int REQ_W = 3 + TID_W + ADDR_W + DATA_W/8 + DATA_W;
    localparam int RSP_W = 3 + TID_W + DATA_W;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [REQ_W-1:0] req = '0;
    logic resp_valid;
    logic resp_ready = 1'b0;
    logic [RSP_W-1:0] resp;
    logic cyc, stb, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0] sel;
    logic s_ack, s_err, late_ack;
    logic [DATA_W-1:0] rdata = '0;
    int mode = 0;

    int total = 0;
    int bad = 0;
    int cyc_count = 0;
    logic cyc_prev;
    logic [ADDR_W-1:0] last_addr;
    logic last_we;
    logic [3:0] last_sel;

    always #5 clk = ~clk;

    m2w_bridge_pipe #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TID_W(TID_W),
        .REQ_DEPTH(2), .RESP_DEPTH(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .mem_if_req_valid(req_valid), .mem_if_req_ready(req_ready), .mem_if_req(req),
        .mem_if_resp_valid(resp_valid), .mem_if_resp_ready(resp_ready), .mem_if_resp(resp),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr),
        .wb_data_o(wdata), .wb_sel_o(sel),
        .wb_ack_i(s_ack | late_ack), .wb_err_i(s_err), .wb_data_i(rdata)
    );

    // Slave: mode 0 acks, mode 1 acks with err, mode 2 never answers.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
        end else if (cyc && stb && !s_ack && !s_err && mode != 2) begin
            s_ack <= 1'b1;
            s_err <= (mode == 1);
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc_prev <= cyc;
        if (cyc && !cyc_prev) cyc_count <= cyc_count + 1;
        if (cyc) begin
            last_addr <= addr;
            last_we   <= we;
            last_sel  <= sel;
        end
    end

    initial late_ack = 1'b0;

    task automatic push(input logic [2:0] ty, input logic [15:0] tid, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req = {ty, tid, a, m, d};
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL push_wait tid=%h: req_ready still %b after %0d cycles, need 1", tid, req_ready, n);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic pop_resp(output logic [RSP_W-1:0] r);
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!resp_valid) begin
            bad++;
            $display("FAIL pop_wait: resp_valid=%b after %0d cycles, need 1", resp_valid, n);
            r = 'x;
        end else begin
            r = resp;
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cyc, stb, we, addr, wdata, sel, resp_valid, resp, req_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b addr=%h rv=%b rdy=%b, need all 0",
                     cyc, stb, we, addr, resp_valid, req_ready);
        end
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || cyc !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%b rv=%b cyc=%b, need 1 0 0", req_ready, resp_valid, cyc);
        end
    endtask

    task automatic test_single_read();
        logic [RSP_W-1:0] r;
        int lat = 0;
        rdata = 32'hCAFEBABE;
        push(3'd0, 16'h0011, 32'h0000_1000, 4'hF, 32'h0);
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL read_latency: got %0d cycles, need 3", lat);
        end
        total++;
        if (last_addr !== 32'h0000_1000 || last_we !== 1'b0) begin
            bad++;
            $display("FAIL read_bus: addr=%h we=%b, need 00001000 0", last_addr, last_we);
        end
        pop_resp(r);
        total++;
        if (r !== {3'd0, 16'h0011, 32'hCAFEBABE}) begin
            bad++;
            $display("FAIL read_resp: got %h, need %h", r, {3'd0, 16'h0011, 32'hCAFEBABE});
        end
    endtask

    task automatic test_back_to_back();
        logic [RSP_W-1:0] r;
        int base = cyc_count;
        for (int i = 1; i <= 4; i++)
            push(3'd1, 16'(i), 32'h2000 + 32'(i), 4'b0011, 32'(i));
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready: req_ready=%b with queues full, need 0", req_ready);
        end
        total++;
        if (cyc_count - base !== 2) begin
            bad++;
            $display("FAIL b2b_bus_cycles: got %0d, need 2", cyc_count - base);
        end
        total++;
        if (last_sel !== 4'b0011 || last_we !== 1'b1) begin
            bad++;
            $display("FAIL b2b_bus: sel=%b we=%b, need 0011 1", last_sel, last_we);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_resp(r);
            total++;
            if (r !== {3'd1, 16'(i), 32'h0}) begin
                bad++;
                $display("FAIL b2b_resp%0d: got %h, need %h", i, r, {3'd1, 16'(i), 32'h0});
            end
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (cyc_count - base !== 4) begin
            bad++;
            $display("FAIL b2b_total_cycles: got %0d, need 4", cyc_count - base);
        end
    endtask

    task automatic test_error();
        logic [RSP_W-1:0] r;
        mode = 1;
        rdata = 32'h5555_AAAA;
        push(3'd0, 16'h0007, 32'h3000, 4'hF, 32'h0);
        pop_resp(r);
        total++;
        if (r !== {3'd2, 16'h0007, 32'h0}) begin
            bad++;
            $display("FAIL err_resp: got %h, need %h", r, {3'd2, 16'h0007, 32'h0});
        end
        mode = 0;
        rdata = 32'h1234_5678;
        push(3'd0, 16'h0008, 32'h3004, 4'hF, 32'h0);
        pop_resp(r);
        total++;
        if (r !== {3'd0, 16'h0008, 32'h1234_5678}) begin
            bad++;
            $display("FAIL err_next: got %h, need %h", r, {3'd0, 16'h0008, 32'h1234_5678});
        end
    endtask

    task automatic test_illegal();
        logic [RSP_W-1:0] r;
        int base = cyc_count;
        push(3'd5, 16'h0009, 32'h4000, 4'hF, 32'hFFFF_FFFF);
        pop_resp(r);
        total++;
        if (r !== {3'd2, 16'h0009, 32'h0}) begin
            bad++;
            $display("FAIL illegal_resp: got %h, need %h", r, {3'd2, 16'h0009, 32'h0});
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (cyc_count !== base) begin
            bad++;
            $display("FAIL illegal_no_bus: %0d cycles issued, need 0", cyc_count - base);
        end
    endtask

`ifdef M2W_TIMEOUT_EN
    task automatic test_timeout();
        logic [RSP_W-1:0] r;
        int n = 0;
        mode = 2;
        push(3'd0, 16'h0033, 32'h5000, 4'hF, 32'h0);
        while (!cyc && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        n = 0;
        while (cyc && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL tmo_length: cyc high %0d cycles, need 16", n);
        end
        @(negedge clk) late_ack = 1'b1;
        @(posedge clk);
        #1 late_ack = 1'b0;
        mode = 0;
        pop_resp(r);
        total++;
        if (r !== {3'd2, 16'h0033, 32'hDEAD_0000}) begin
            bad++;
            $display("FAIL tmo_resp: got %h, need %h", r, {3'd2, 16'h0033, 32'hDEAD_0000});
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_late_ack: resp_valid=%b, need 0", resp_valid);
        end
    endtask
`endif

    task automatic test_reset_mid_bus();
        logic [RSP_W-1:0] r;
        int n = 0;
        int snap;
        mode = 2;
        push(3'd0, 16'h0044, 32'h6000, 4'hF, 32'h0);
        push(3'd1, 16'h0045, 32'h6004, 4'hF, 32'h1);
        while (!cyc && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({cyc, stb, we, addr, wdata, sel, resp_valid, resp, req_ready} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: cyc=%b stb=%b we=%b rv=%b rdy=%b, need all 0",
                     cyc, stb, we, resp_valid, req_ready);
        end
        snap = cyc_count;
        mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || cyc_count !== snap || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_stale: rv=%b new_cycles=%0d rdy=%b, need 0 0 1",
                     resp_valid, cyc_count - snap, req_ready);
        end
        rdata = 32'h0BAD_F00D;
        push(3'd0, 16'h0055, 32'h7000, 4'hF, 32'h0);
        pop_resp(r);
        total++;
        if (r !== {3'd0, 16'h0055, 32'h0BAD_F00D}) begin
            bad++;
            $display("FAIL rst_mid_recover: got %h, need %h", r, {3'd0, 16'h0055, 32'h0BAD_F00D});
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_error();
        test_illegal();
`ifdef M2W_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
